// File: rtl/prog_down_timer.sv
// Loadable N-bit down timer with start/expire control.
// A programmed count M is captured by load_i. start_i then runs a countdown.
// done_tick_o pulses once, M enabled clocks after start. M = 0 behaves as M = 1.
// Optional feature: define PROG_DOWN_TIMER_AUTO_RELOAD_EN for periodic mode.
// In that mode, expiry reloads the count and keeps running instead of parking in DONE.
module prog_down_timer #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [N-1:0] d_i,
    input  logic         start_i,
    input  logic         en_i,
    output logic [N-1:0] q_o,
    output logic         busy_o,
    output logic         done_tick_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [N-1:0] ONE = N'(1);

    state_e       state_q, state_d;
    logic [N-1:0] r_q, r_d;
    logic [N-1:0] reload_q, reload_d;
    logic         tick_q, tick_d;

    // State, count, reload value and tick registers; reset aborts any countdown at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            r_q      <= '0;
            reload_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            reload_q <= reload_d;
            tick_q   <= tick_d;
        end
    end

    // Next-state logic: load beats start, start beats the count enable
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        reload_d = reload_q;
        tick_d   = 1'b0;

        if (load_i) begin
            // A load always returns to IDLE, and it swallows a start in the same cycle.
            reload_d = d_i;
            r_d      = d_i;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    // The start cycle itself needs no enable. The count begins on the next enabled edge.
                    if (start_i) begin
                        r_d     = reload_q;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // start_i is deliberately ignored here: there is no mid-count restart.
                    if (en_i) begin
                        // Treating 0 like 1 makes M = 0 expire after one edge.
                        // It also keeps the counter from wrapping below zero.
                        if (r_q <= ONE) begin
                            tick_d = 1'b1;
`ifdef PROG_DOWN_TIMER_AUTO_RELOAD_EN
                            r_d     = reload_q;
                            state_d = RUN;
`else
                            r_d     = '0;
                            state_d = DONE;
`endif
                        end else begin
                            r_d = r_q - ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are straight register taps
    always_comb begin
        q_o         = r_q;
        busy_o      = (state_q == RUN);
        done_tick_o = tick_q;
    end

endmodule

// File: tb/tb_prog_down_timer.sv
// Testbench for prog_down_timer, using directed table vectors and hand-written corner sequences.
// It covers both builds: when PROG_DOWN_TIMER_AUTO_RELOAD_EN is defined, the periodic expectations are used.
module tb_prog_down_timer;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       load_i = 1'b0;
    logic [7:0] d_i = '0;
    logic       start_i = 1'b0;
    logic       en_i = 1'b0;
    logic [7:0] q_o;
    logic       busy_o;
    logic       done_tick_o;

    int n_checks = 0;
    int n_fail   = 0;

    prog_down_timer #(.N(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load_i),
        .d_i         (d_i),
        .start_i     (start_i),
        .en_i        (en_i),
        .q_o         (q_o),
        .busy_o      (busy_o),
        .done_tick_o (done_tick_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic       st;
        logic       en;
        logic [7:0] q;
        logic       busy;
        logic       tick;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    task automatic add(input logic ld, input logic [7:0] d, input logic st, input logic en,
                       input logic [7:0] q, input logic busy, input logic tick);
        vecs[nv].ld   = ld;
        vecs[nv].d    = d;
        vecs[nv].st   = st;
        vecs[nv].en   = en;
        vecs[nv].q    = q;
        vecs[nv].busy = busy;
        vecs[nv].tick = tick;
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive the inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic ld, input logic [7:0] d, input logic st, input logic en);
        @(negedge clk_i);
        load_i  = ld;
        d_i     = d;
        start_i = st;
        en_i    = en;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int cycles;
        int first_tick;

        // ---------------- vector table ----------------
`ifndef PROG_DOWN_TIMER_AUTO_RELOAD_EN
        // one-shot d=3
        add(1, 3, 0, 0, 3, 0, 0);
        add(0, 0, 1, 1, 3, 1, 0);
        add(0, 0, 0, 1, 2, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // pause d=4: expiry 7 edges after start
        add(1, 4, 0, 0, 4, 0, 0);
        add(0, 0, 1, 1, 4, 1, 0);
        add(0, 0, 0, 1, 3, 1, 0);
        add(0, 0, 0, 1, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        // load and start together: load wins
        add(1, 9, 1, 1, 9, 0, 0);
        add(0, 0, 0, 1, 9, 0, 0);
        // start during RUN is ignored
        add(0, 0, 1, 1, 9, 1, 0);
        add(0, 0, 1, 1, 8, 1, 0);
        add(0, 0, 1, 1, 7, 1, 0);
        // M = 0 expires one edge after start; restart from DONE
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        // load during RUN aborts to IDLE
        add(1, 2, 0, 0, 2, 0, 0);
        add(0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(1, 6, 0, 1, 6, 0, 0);
`else
        // periodic d=2: q = 2,1,2,1,...
        add(1, 2, 0, 0, 2, 0, 0);
        add(0, 0, 1, 1, 2, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 2, 1, 1);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 2, 1, 1);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 2, 1, 1);
        add(1, 5, 0, 1, 5, 0, 0);
        add(0, 0, 0, 1, 5, 0, 0);
        // periodic M = 0 ticks on every enabled edge
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 0);
        add(1, 7, 0, 0, 7, 0, 0);
`endif

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk_i);
        #1;
        check("reset q", q_o, 0);
        check("reset busy", busy_o, 0);
        check("reset tick", done_tick_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < nv; i++) begin
            step(vecs[i].ld, vecs[i].d, vecs[i].st, vecs[i].en);
            $display("vec %0d: ld=%0d d=%0d st=%0d en=%0d -> q=%0d busy=%0d tick=%0d",
                     i, vecs[i].ld, vecs[i].d, vecs[i].st, vecs[i].en, q_o, busy_o, done_tick_o);
            check($sformatf("vec%0d q", i), q_o, vecs[i].q);
            check($sformatf("vec%0d busy", i), busy_o, vecs[i].busy);
            check($sformatf("vec%0d tick", i), done_tick_o, vecs[i].tick);
        end

        // ---------------- async reset mid-RUN at q=5 ----------------
        step(1, 8, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("pre-reset q", q_o, 5);
        #2;
        rst_ni = 1'b0;
        #1;
        $display("async reset: q=%0d busy=%0d tick=%0d", q_o, busy_o, done_tick_o);
        check("async reset q", q_o, 0);
        check("async reset busy", busy_o, 0);
        check("async reset tick", done_tick_o, 0);
        @(posedge clk_i);
        #1;
        check("reset held tick", done_tick_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(0, 0, 0, 1);
        check("post-reset busy", busy_o, 0);
        check("post-reset q", q_o, 0);

        // ---------------- full range d=255 ----------------
        step(1, 255, 0, 0);
        step(0, 0, 1, 1);
        cycles = 0;
        first_tick = -1;
        while (first_tick < 0 && cycles < 300) begin
            step(0, 0, 0, 1);
            cycles++;
            if (done_tick_o) first_tick = cycles;
        end
        $display("d=255: tick after %0d enabled edges, q=%0d busy=%0d", first_tick, q_o, busy_o);
        check("d255 tick edge", first_tick, 255);
`ifndef PROG_DOWN_TIMER_AUTO_RELOAD_EN
        check("d255 final q", q_o, 0);
        check("d255 final busy", busy_o, 0);
`else
        check("d255 final q", q_o, 255);
        check("d255 final busy", busy_o, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
